bcd_display_driver: RTL

BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

---
 rtl/bcd_disp_pkg.sv | 11 +
 rtl/bcd_to_seg.sv | 14 +
 rtl/bcd_display_driver.sv | 68 ++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: segment patterns and code constants shared by the BCD display driver
package bcd_disp_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] CODE_OVF = 4'hF;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD code to active-low {g,f,e,d,c,b,a} decoder
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);
    // Forced blank wins; 15 marks overflow as a dash, 10..14 stay dark
    always_comb
        seg = blank ? SEG_BLANK :
              code == CODE_OVF ? SEG_DASH :
              code > 4'd9 ? SEG_BLANK : SEG_DIGIT[code];
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: 4-digit multiplexed 7-segment driver with frame snapshot; BCD_LZB_EN enables leading-zero blanking
module bcd_display_driver
    import bcd_disp_pkg::*;
#(
    parameter int         REFRESH_DIV = 1024,
    parameter logic [3:0] DP_MASK     = 4'b0000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An,
    output logic       FrameDone
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0] dec_seg;
    logic tick, guard;
    assign tick = cnt == CW'(REFRESH_DIV - 1);
    assign guard = cnt == '0;
`ifdef BCD_LZB_EN
    logic above_ok;
    // A digit goes dark while it is zero and nothing above it is a real digit or a dash
    always_comb begin
        blank = '0;
        above_ok = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            blank[i] = above_ok && shadow[i] == 4'd0;
            above_ok = above_ok && (shadow[i] == 4'd0 || (shadow[i] > 4'd9 && shadow[i] != CODE_OVF));
        end
    end
`else
    assign blank = '0;
`endif
    bcd_to_seg u_dec (
        .code (shadow[idx]),
        .blank(blank[idx]),
        .seg  (dec_seg)
    );
    // Slot/digit counters, frame snapshot and registered display outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt <= '0;
            idx <= '0;
            shadow <= '0;
            An <= 4'hF;
            Seg <= SEG_BLANK;
            Dp <= 1'b1;
            FrameDone <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            idx <= tick ? idx + 2'd1 : idx;
            if (tick && idx == 2'd3)
                shadow <= {BCD3, BCD2, BCD1, BCD0};
            FrameDone <= tick && idx == 2'd3;
            An <= guard ? 4'hF : ~(4'b0001 << idx);
            Seg <= guard ? SEG_BLANK : dec_seg;
            Dp <= guard | ~DP_MASK[idx];
        end
    end
endmodule
